// File: rtl/ddr_read_engine.sv
// rtl/ddr_read_engine.sv - credit-limited MIG read engine with local FIFO and stream output
// Issues READ commands over an address window and streams returned words in order.
module ddr_read_engine #(
  parameter int unsigned          ADDR_W     = 27,
  parameter int unsigned          ADDR_STEP  = 8,
  parameter longint unsigned      ADDR_LIMIT = 64'd134217728,
  parameter int unsigned          COUNT_W    = 24,
  parameter int unsigned          FIFO_DEPTH = 16
) (
  input  logic               ui_clk,
  input  logic               sys_rst,
  input  logic               init_calib_complete,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [COUNT_W-1:0] word_count,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  app_addr,
  output logic [2:0]         app_cmd,
  output logic               app_en,
  input  logic               app_rdy,
  input  logic [63:0]        app_rd_data,
  input  logic               app_rd_data_valid,
  input  logic               app_rd_data_end,
  output logic [63:0]        out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               ovf_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [COUNT_W-1:0] r_total;
  logic [COUNT_W-1:0] r_issued;
  logic [CNT_W-1:0]   r_outstanding;
  logic [CNT_W-1:0]   r_fifo_cnt;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [63:0]        r_mem [FIFO_DEPTH];
  logic               r_pending;
  logic               r_done;
  logic               r_ovf;

  logic               w_start_ok;
  logic               w_cmd_acc;
  logic               w_last_cmd;
  logic               w_more;
  logic               w_beat_ok;
  logic               w_credit_ret;
  logic               w_pop;
  logic               w_credit_ok;
  logic [CNT_W:0]     w_credit_sum;
  logic [63:0]        w_addr_sum;
  logic [ADDR_W-1:0]  w_addr_nxt;

  assign busy      = (r_state != S_IDLE) | r_done;
  assign done      = r_done;
  assign app_cmd   = 3'b001;
  assign app_addr  = r_addr;
  assign out_valid = (r_fifo_cnt != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign ovf_err   = r_ovf;

  assign w_start_ok   = start & ~busy;
  assign w_more       = (r_issued < r_total);
  assign w_credit_sum = {1'b0, r_outstanding} + {1'b0, r_fifo_cnt};
  assign w_credit_ok  = (w_credit_sum < (CNT_W + 1)'(FIFO_DEPTH));
  // Once raised, app_en is held by r_pending until MIG takes the command.
  assign app_en       = (r_state == S_ISSUE) & w_more &
                        (r_pending | (w_credit_ok & init_calib_complete));
  assign w_cmd_acc    = app_en & app_rdy;
  assign w_last_cmd   = w_cmd_acc & ((r_issued + COUNT_W'(1)) == r_total);
  assign w_beat_ok    = app_rd_data_valid & (r_outstanding != '0);
  assign w_credit_ret = w_beat_ok & app_rd_data_end;
  assign w_pop        = out_valid & out_ready;

  assign w_addr_sum = 64'(r_addr) + 64'(ADDR_STEP);
  assign w_addr_nxt = (w_addr_sum >= ADDR_LIMIT) ? '0 : w_addr_sum[ADDR_W-1:0];

  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = (word_count == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_last_cmd) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((r_outstanding == '0) && (r_fifo_cnt == '0)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_addr    <= '0;
      r_total   <= '0;
      r_issued  <= '0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_pending <= app_en & ~app_rdy;
      r_done    <= (r_state == S_DONE);
      if (w_start_ok) begin
        r_addr   <= start_addr;
        r_total  <= word_count;
        r_issued <= '0;
      end else if (w_cmd_acc) begin
        r_addr   <= w_addr_nxt;
        r_issued <= r_issued + COUNT_W'(1);
      end
    end
  end

  // A beat with no credit outstanding is stale (pre-reset) or spurious: drop and flag.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_outstanding <= '0;
      r_ovf         <= 1'b0;
    end else begin
      if (app_rd_data_valid && (r_outstanding == '0)) begin
        r_ovf <= 1'b1;
      end
      case ({w_cmd_acc, w_credit_ret})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_beat_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_beat_ok, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge ui_clk) begin
    if (w_beat_ok) begin
      r_mem[r_wr_ptr] <= app_rd_data;
    end
  end

endmodule

// File: tb/tb_ddr_read_engine.sv
// tb/tb_ddr_read_engine.sv - scoreboard bench for ddr_read_engine with a simple in-order MIG model
module tb_ddr_read_engine;

  localparam int unsigned     ADDR_W  = 27;
  localparam int unsigned     COUNT_W = 24;
  localparam longint unsigned LIMIT   = 64'd134217728;

  logic               ui_clk = 1'b0;
  logic               sys_rst = 1'b0;
  logic               init_calib_complete = 1'b0;
  logic               start = 1'b0;
  logic [ADDR_W-1:0]  start_addr = '0;
  logic [COUNT_W-1:0] word_count = '0;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  app_addr;
  logic [2:0]         app_cmd;
  logic               app_en;
  logic               app_rdy = 1'b0;
  logic [63:0]        app_rd_data = '0;
  logic               app_rd_data_valid = 1'b0;
  logic               app_rd_data_end = 1'b0;
  logic [63:0]        out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               ovf_err;

  ddr_read_engine dut (
    .ui_clk(ui_clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
    .start(start), .start_addr(start_addr), .word_count(word_count),
    .busy(busy), .done(done), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(app_en), .app_rdy(app_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .ovf_err(ovf_err)
  );

  always #5 ui_clk = ~ui_clk;

  typedef struct {
    logic [63:0] data;
    int          due;
  } beat_t;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [63:0]       exp_data_q[$];
  beat_t             ret_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  int acc_cnt, pop_cnt, done_cnt, busy_cnt, en_cnt;
  int rdy_pct = 100;
  int ordy_pct = 100;
  logic [31:0]       tid = '0;
  logic              prev_hold = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_data(input logic [ADDR_W-1:0] a);
    return {tid, 5'b0, a};
  endfunction

  // Called just after a falling edge: drive inputs, sample what the next rising edge will transfer.
  task automatic cyc();
    app_rdy   = ($urandom_range(99) < rdy_pct);
    out_ready = ($urandom_range(99) < ordy_pct);
    if (ret_q.size() > 0 && ret_q[0].due <= cyc_n) begin
      app_rd_data_valid = 1'b1;
      app_rd_data_end   = 1'b1;
      app_rd_data       = ret_q[0].data;
      void'(ret_q.pop_front());
    end else begin
      app_rd_data_valid = 1'b0;
      app_rd_data_end   = 1'b0;
      app_rd_data       = '0;
    end
    #1;
    if (sys_rst) begin
      if (prev_hold) begin
        chk("hold_en", 64'(app_en), 64'd1);
        chk("hold_addr", 64'(app_addr), 64'(prev_addr));
      end
      prev_hold = app_en & ~app_rdy;
      prev_addr = app_addr;
      if (app_en) en_cnt++;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (app_en && app_rdy) begin
        acc_cnt++;
        chk("cmd_expected", 64'(exp_addr_q.size() > 0), 64'd1);
        if (exp_addr_q.size() > 0) chk("app_addr", 64'(app_addr), 64'(exp_addr_q.pop_front()));
        ret_q.push_back('{mk_data(app_addr), cyc_n + 3});
      end
      if (out_valid && out_ready) begin
        pop_cnt++;
        chk("word_expected", 64'(exp_data_q.size() > 0), 64'd1);
        if (exp_data_q.size() > 0) chk("out_data", out_data, exp_data_q.pop_front());
      end
    end
    @(posedge ui_clk);
    @(negedge ui_clk);
    cyc_n++;
  endtask

  task automatic launch(input logic [ADDR_W-1:0] addr, input int count, input int t);
    longint unsigned a;
    tid = 32'(t);
    a = 64'(addr);
    for (int i = 0; i < count; i++) begin
      exp_addr_q.push_back(a[ADDR_W-1:0]);
      exp_data_q.push_back(mk_data(a[ADDR_W-1:0]));
      a = a + 64'd8;
      if (a >= LIMIT) a = 0;
    end
    acc_cnt = 0; pop_cnt = 0; done_cnt = 0; busy_cnt = 0; en_cnt = 0;
    start_addr = addr;
    word_count = COUNT_W'(count);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      cyc();
      n++;
    end
    chk({tag, "_in_time"}, 64'(n < budget), 64'd1);
    chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    chk({tag, "_cmds_left"}, 64'(exp_addr_q.size()), 64'd0);
    chk({tag, "_words_left"}, 64'(exp_data_q.size()), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf_err), 64'd0);
  endtask

  initial begin
    int n;
    beat_t b;
    repeat (3) @(negedge ui_clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_app_en", 64'(app_en), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ovf", 64'(ovf_err), 64'd0);
    chk("rst_app_addr", 64'(app_addr), 64'd0);
    chk("app_cmd", 64'(app_cmd), 64'd1);
    @(negedge ui_clk);
    sys_rst = 1'b1;

    // 1: basic run, with calibration held off at first
    launch(27'h100, 4, 1);
    repeat (4) cyc();
    chk("calib_gate", 64'(en_cnt), 64'd0);
    init_calib_complete = 1'b1;
    wait_done("t1", 200);
    chk("t1_words", 64'(pop_cnt), 64'd4);

    // 2: credit limit with a stalled stream
    ordy_pct = 0;
    launch(27'h2000, 40, 2);
    repeat (40) cyc();
    chk("t2_credit_accepts", 64'(acc_cnt), 64'd16);
    chk("t2_en_low", 64'(app_en), 64'd0);
    chk("t2_fifo_valid", 64'(out_valid), 64'd1);
    ordy_pct = 100;
    wait_done("t2", 600);
    chk("t2_words", 64'(pop_cnt), 64'd40);

    // 3: window wrap
    launch(ADDR_W'(LIMIT - 64'd16), 4, 3);
    wait_done("t3", 200);
    chk("t3_words", 64'(pop_cnt), 64'd4);

    // 4: random command and stream backpressure
    rdy_pct = 50;
    ordy_pct = 70;
    launch(27'h40000, 8, 4);
    wait_done("t4", 600);
    chk("t4_accepts", 64'(acc_cnt), 64'd8);
    chk("t4_words", 64'(pop_cnt), 64'd8);
    rdy_pct = 100;
    ordy_pct = 100;

    // 5: zero-length request
    launch(27'h500, 0, 5);
    wait_done("t5", 20);
    chk("t5_busy_cycles", 64'(busy_cnt), 64'd2);
    chk("t5_en_cycles", 64'(en_cnt), 64'd0);

    // 6: reset mid-run, then a stale beat from before reset
    launch(27'h3000, 8, 6);
    n = 0;
    while (acc_cnt < 3 && n < 20) begin
      cyc();
      n++;
    end
    chk("t6_three_accepts", 64'(acc_cnt), 64'd3);
    chk("t6_beats_pending", 64'(ret_q.size() > 0), 64'd1);
    if (ret_q.size() > 0) begin
      b = ret_q[0];
      ret_q.delete();
      b.due = cyc_n + 4;
      ret_q.push_back(b);
    end
    sys_rst = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_app_en", 64'(app_en), 64'd0);
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_app_addr", 64'(app_addr), 64'd0);
    chk("t6_rst_ovf", 64'(ovf_err), 64'd0);
    cyc();
    sys_rst = 1'b1;
    prev_hold = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (6) cyc();
    chk("t6_ovf_sticky", 64'(ovf_err), 64'd1);
    chk("t6_stale_dropped", 64'(out_valid), 64'd0);
    chk("t6_idle", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
